// File: rtl/lift_scan_ctrl.sv
// lift_scan_ctrl: N-floor lift controller with SCAN service order.
// Floor requests are latched into a pending bitmap. The car keeps its
// direction while requests lie ahead, then reverses. Travel time per floor
// and door dwell time come from internal counters.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  request strobe, sampled every rising edge
//   req_floor  requested floor (out-of-range values pulse req_err)
//   floor      current car floor
//   moving_up  car travelling upward
//   moving_dn  car travelling downward
//   door_open  door held open
//   arrived    one-cycle pulse on the edge that opens the door
//   req_err    one-cycle pulse for an out-of-range request
//   pending    outstanding-request bitmap
module lift_scan_ctrl #(
  parameter int N_FLOORS      = 8,
  parameter int FLOOR_W       = $clog2(N_FLOORS),
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  output logic [FLOOR_W-1:0]  floor,
  output logic                moving_up,
  output logic                moving_dn,
  output logic                door_open,
  output logic                arrived,
  output logic                req_err,
  output logic [N_FLOORS-1:0] pending
);
  localparam int TCNT_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] T_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0] D_LAST = DCNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

  state_e              state_q, state_d;
  logic                dir_up_q, dir_up_d;
  logic [FLOOR_W-1:0]  floor_q, floor_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                arrived_q, arrived_d;
  logic                req_err_q, req_err_d;

  logic                above, below, here, step_hit;
  logic                ahead, behind;
  logic [FLOOR_W-1:0]  step_floor, arr_floor;
  logic                req_in, door_hit, arr_clr;

  // Pending-set summaries relative to the current floor, all from the
  // registered bitmap.
  always_comb begin
    above      = 1'b0;
    below      = 1'b0;
    here       = 1'b0;
    step_hit   = 1'b0;
    step_floor = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i] && i >  int'(floor_q))    above    = 1'b1;
      if (pending_q[i] && i <  int'(floor_q))    below    = 1'b1;
      if (pending_q[i] && i == int'(floor_q))    here     = 1'b1;
      if (pending_q[i] && i == int'(step_floor)) step_hit = 1'b1;
    end
    ahead  = dir_up_q ? above : below;
    behind = dir_up_q ? below : above;
  end

  always_comb begin
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    floor_d   = floor_q;
    tcnt_d    = tcnt_q;
    dcnt_d    = dcnt_q;
    arrived_d = 1'b0;
    arr_clr   = 1'b0;
    arr_floor = floor_q;
    req_in    = req_valid && (int'(req_floor) < N_FLOORS);
    req_err_d = req_valid && !req_in;
    // Re-request of the open-door floor extends dwell instead of latching.
    door_hit  = req_in && (state_q == S_DOOR) && (req_floor == floor_q);

    case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d   = S_DOOR;
          dcnt_d    = '0;
          arrived_d = 1'b1;
          arr_clr   = 1'b1;
        end else if (ahead) begin
          state_d = S_MOVE;
          tcnt_d  = '0;
        end else if (behind) begin
          state_d  = S_MOVE;
          dir_up_d = !dir_up_q;
          tcnt_d   = '0;
        end
      end
      S_MOVE: begin
        if (tcnt_q == T_LAST) begin
          // A request remains ahead while moving, so the step stays in range.
          tcnt_d    = '0;
          floor_d   = step_floor;
          arr_floor = step_floor;
          if (step_hit) begin
            state_d   = S_DOOR;
            dcnt_d    = '0;
            arrived_d = 1'b1;
            arr_clr   = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_DOOR: begin
        if (door_hit) begin
          dcnt_d = '0;
        end else if (dcnt_q == D_LAST) begin
          dcnt_d = '0;
          if (ahead) begin
            state_d = S_MOVE;
            tcnt_d  = '0;
          end else if (behind) begin
            state_d  = S_MOVE;
            dir_up_d = !dir_up_q;
            tcnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Arrival clear wins over a same-edge request for that floor.
    pending_d = pending_q;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (req_in && !door_hit && int'(req_floor) == i) pending_d[i] = 1'b1;
      if (arr_clr && int'(arr_floor) == i)             pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dir_up_q  <= 1'b1;
      floor_q   <= '0;
      pending_q <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      arrived_q <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_up_q  <= dir_up_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      arrived_q <= arrived_d;
      req_err_q <= req_err_d;
    end
  end

  assign floor     = floor_q;
  assign moving_up = (state_q == S_MOVE) && dir_up_q;
  assign moving_dn = (state_q == S_MOVE) && !dir_up_q;
  assign door_open = (state_q == S_DOOR);
  assign arrived   = arrived_q;
  assign req_err   = req_err_q;
  assign pending   = pending_q;
endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Bench for lift_scan_ctrl: directed scenarios plus random requests, checked
// every cycle against a countdown-based behavioural model.
module tb_lift_scan_ctrl;
  localparam int NF = 8;
  localparam int TRAVEL = 2;
  localparam int DWELL = 3;
  localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [2:0]    req_floor = '0;
  logic [2:0]    floor;
  logic          moving_up, moving_dn, door_open, arrived, req_err;
  logic [NF-1:0] pending;

  logic          v6 = 1'b0;
  logic [2:0]    f6 = '0;
  logic [2:0]    floor6;
  logic          up6, dn6, door6, arr6, err6;
  logic [5:0]    pend6;

  int checks = 0;
  int errors = 0;

  // model state
  int      m_mode, m_floor, m_dir, m_wait;
  bit      m_arr, m_err;
  bit [7:0] m_pend;

  int arr_q[$];
  bit seen_dn;
  int dn_floor, dn_arrs;

  always #5 clk = ~clk;

  lift_scan_ctrl #(.N_FLOORS(NF), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DWELL)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_floor(req_floor),
    .floor(floor), .moving_up(moving_up), .moving_dn(moving_dn),
    .door_open(door_open), .arrived(arrived), .req_err(req_err), .pending(pending));

  lift_scan_ctrl #(.N_FLOORS(6)) dut6 (
    .clk(clk), .reset(rst_n), .req_valid(v6), .req_floor(f6),
    .floor(floor6), .moving_up(up6), .moving_dn(dn6),
    .door_open(door6), .arrived(arr6), .req_err(err6), .pending(pend6));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_floor = 0; m_dir = 1; m_wait = 0;
    m_arr = 0; m_err = 0; m_pend = '0;
  endtask

  // Direction to travel given the request set: keep going while anything
  // lies ahead, else turn toward what lies behind, else 0 (stay put).
  function automatic int choose(input bit [7:0] p);
    bit up_any = 0, dn_any = 0;
    for (int i = 0; i < NF; i++) begin
      if (p[i] && i > m_floor) up_any = 1;
      if (p[i] && i < m_floor) dn_any = 1;
    end
    if (m_dir > 0) return up_any ? 1 : (dn_any ? -1 : 0);
    return dn_any ? -1 : (up_any ? 1 : 0);
  endfunction

  task automatic model_step(input bit v, input int f);
    bit [7:0] p = m_pend;
    bit inr = v && (f < NF);
    bit hit = inr && (m_mode == M_DOOR) && (f == m_floor);
    int way;
    m_arr = 0;
    m_err = v && !inr;
    case (m_mode)
      M_IDLE: begin
        if (p[m_floor]) begin
          m_mode = M_DOOR; m_wait = DWELL; m_arr = 1;
        end else begin
          way = choose(p);
          if (way != 0) begin m_mode = M_MOVE; m_dir = way; m_wait = TRAVEL; end
        end
      end
      M_MOVE: begin
        m_wait--;
        if (m_wait == 0) begin
          m_floor += m_dir;
          if (p[m_floor]) begin m_mode = M_DOOR; m_wait = DWELL; m_arr = 1; end
          else m_wait = TRAVEL;
        end
      end
      default: begin
        if (hit) m_wait = DWELL;
        else begin
          m_wait--;
          if (m_wait == 0) begin
            way = choose(p);
            if (way != 0) begin m_mode = M_MOVE; m_dir = way; m_wait = TRAVEL; end
            else m_mode = M_IDLE;
          end
        end
      end
    endcase
    if (inr && !hit) p[f] = 1;
    if (m_arr) p[m_floor] = 0;
    m_pend = p;
  endtask

  task automatic check_all();
    chk("floor", floor, m_floor);
    chk("moving_up", moving_up, (m_mode == M_MOVE) && (m_dir > 0));
    chk("moving_dn", moving_dn, (m_mode == M_MOVE) && (m_dir < 0));
    chk("door_open", door_open, m_mode == M_DOOR);
    chk("arrived", arrived, m_arr);
    chk("req_err", req_err, m_err);
    chk("pending", pending, m_pend);
  endtask

  task automatic tick(input bit v, input int f);
    req_valid = v;
    req_floor = 3'(f);
    @(posedge clk);
    model_step(v, f);
    #1;
    check_all();
    if (arrived) arr_q.push_back(int'(floor));
    if (moving_dn && !seen_dn) begin
      seen_dn = 1; dn_floor = int'(floor); dn_arrs = arr_q.size();
    end
    req_valid = 0; req_floor = '0; v6 = 0; f6 = '0;
  endtask

  task automatic drain();
    int k = 0;
    while (k < 300 && !(m_mode == M_IDLE && m_pend == 0)) begin tick(0, 0); k++; end
    chk("drain_timeout", k < 300, 1);
  endtask

  initial begin
    int k, dcount;
    model_reset();
    #2;
    chk("rst_floor", floor, 0);
    chk("rst_pending", pending, 0);
    chk("rst_outs", {moving_up, moving_dn, door_open, arrived, req_err}, 0);
    #10 rst_n = 1'b1;

    // 6-floor variant: out-of-range request only pulses req_err
    v6 = 1; f6 = 3'd7;
    tick(0, 0);
    chk("n6_err", err6, 1);
    chk("n6_pend", pend6, 0);
    chk("n6_state", {floor6, up6, dn6, door6, arr6}, 0);
    v6 = 1; f6 = 3'd5;
    tick(0, 0);
    chk("n6_err_clr", err6, 0);
    chk("n6_pend5", pend6, 6'b100000);

    // floor 0 -> 3 timing
    tick(1, 3);
    for (int i = 1; i <= 10; i++) begin
      tick(0, 0);
      chk("t2_floor", floor, (i < 3) ? 0 : (i < 5) ? 1 : (i < 7) ? 2 : 3);
      if (i == 1) chk("t2_move", moving_up, 1);
      if (i == 7) chk("t2_arrive", {arrived, door_open}, 2'b11);
      if (i == 9) chk("t2_door_last", door_open, 1);
      if (i == 10) chk("t2_idle", {door_open, moving_up, moving_dn}, 0);
    end

    // idle at 5, request 5: door next edge, no move
    tick(1, 5);
    drain();
    tick(1, 5);
    chk("t6_pend", pending, 8'h20);
    tick(0, 0);
    chk("t6_door", {door_open, arrived, moving_up, moving_dn}, 4'b1100);
    chk("t6_floor", floor, 5);
    drain();

    // reset while moving down past floor 2
    tick(1, 0);
    k = 0;
    while (k < 50 && !(m_floor == 2 && m_mode == M_MOVE)) begin tick(0, 0); k++; end
    chk("t1_reach", k < 50, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_floor", floor, 0);
    chk("t1_pending", pending, 0);
    chk("t1_outs", {moving_up, moving_dn, door_open, arrived, req_err}, 0);
    @(posedge clk); #1;
    chk("t1_hold", {floor, moving_up, moving_dn, door_open}, 0);
    rst_n = 1'b1;
    model_reset();

    // SCAN order: at 2 going up with 5 pending, add 1 and 4
    tick(1, 5);
    k = 0;
    while (k < 50 && m_floor != 2) begin tick(0, 0); k++; end
    chk("t3_reach", k < 50, 1);
    arr_q.delete();
    seen_dn = 0;
    tick(1, 1);
    tick(1, 4);
    drain();
    chk("t3_count", arr_q.size(), 3);
    if (arr_q.size() == 3) begin
      chk("t3_first", arr_q[0], 4);
      chk("t3_second", arr_q[1], 5);
      chk("t3_third", arr_q[2], 1);
    end
    chk("t3_dn_floor", dn_floor, 5);
    chk("t3_dn_after", dn_arrs, 2);

    // door re-request on its 2nd cycle extends dwell to 5
    tick(1, 4);
    k = 0;
    while (k < 50 && !arrived) begin tick(0, 0); k++; end
    chk("t4_arrive", arrived, 1);
    dcount = 1;
    tick(0, 0);
    dcount += door_open;
    tick(1, 4);
    dcount += door_open;
    chk("t4_pend", pending[4], 0);
    k = 0;
    while (k < 20 && door_open) begin
      tick(0, 0);
      dcount += door_open;
      chk("t4_pend_hold", pending[4], 0);
      k++;
    end
    chk("t4_dwell", dcount, 5);

    // random traffic
    for (int i = 0; i < 800; i++)
      tick($urandom_range(3) == 0, $urandom_range(NF - 1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
